// File: rtl/vector_reg_bank_hi_pkg.sv
// Shared definitions for the upper vector register bank (V8..V15) and its serial loader.
package vector_reg_bank_hi_pkg;

  localparam int VEC_I = 20;
  localparam int VEC_L = 8;

  typedef logic [VEC_I-1:0][VEC_L-1:0] vec_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  localparam logic [3:0] VBANK_HI_BASE = 4'b1000;

endpackage

// File: rtl/vector_lane_loader.sv
// Lane-serial load engine: accepts one element per ready/valid handshake and
// emits a per-cycle lane write strobe for the register bank.
module vector_lane_loader
  import vector_reg_bank_hi_pkg::*;
#(
  parameter int I  = VEC_I,
  parameter int L  = VEC_L,
  parameter int CW = (I > 1) ? $clog2(I) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic [3:0]    ld_addr,
  input  logic          ld_valid,
  input  logic [L-1:0]  ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          ld_err,
  output logic          lane_we,
  output logic [CW-1:0] lane_idx,
  output logic [2:0]    lane_reg,
  output logic [L-1:0]  lane_data
);

  ld_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    reg_idx;
  logic          err_q;

  // Handshake outputs depend on state only, so there is no valid->ready path.
  assign ld_ready  = (state == LD_LOAD);
  assign ld_busy   = (state != LD_IDLE);
  assign ld_done   = (state == LD_DONE);
  assign ld_err    = err_q;

  assign lane_we   = ld_ready && ld_valid;
  assign lane_idx  = cnt;
  assign lane_reg  = reg_idx;
  assign lane_data = ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LD_IDLE;
      cnt     <= '0;
      reg_idx <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (ld_start) begin
            if (ld_addr[3] == VBANK_HI_BASE[3]) begin
              reg_idx <= ld_addr[2:0];
              cnt     <= '0;
              state   <= LD_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LD_LOAD: begin
          // The final accept leaves the counter at I-1 rather than wrapping.
          if (ld_valid) begin
            if (cnt == CW'(I - 1)) begin
              state <= LD_DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        LD_DONE: begin
          state <= LD_IDLE;
        end
        default: begin
          state <= LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vector_reg_bank_hi.sv
// Storage for vector registers V8..V15 with a masked full-vector write port
// and a lane-serial load engine; contents drive D08..D15 continuously.
module vector_reg_bank_hi
  import vector_reg_bank_hi_pkg::*;
#(
  parameter int I = VEC_I,
  parameter int L = VEC_L
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [I-1:0]        wr_mask,
  input  logic [I-1:0][L-1:0] wr_data,
  input  logic                ld_start,
  input  logic [3:0]          ld_addr,
  input  logic                ld_valid,
  input  logic [L-1:0]        ld_data,
  output logic                ld_ready,
  output logic                ld_busy,
  output logic                ld_done,
  output logic                ld_err,
  output logic [I-1:0][L-1:0] D08,
  output logic [I-1:0][L-1:0] D09,
  output logic [I-1:0][L-1:0] D10,
  output logic [I-1:0][L-1:0] D11,
  output logic [I-1:0][L-1:0] D12,
  output logic [I-1:0][L-1:0] D13,
  output logic [I-1:0][L-1:0] D14,
  output logic [I-1:0][L-1:0] D15
);

  localparam int CW = (I > 1) ? $clog2(I) : 1;

  logic [I-1:0][L-1:0] bank [8];

  logic          lane_we;
  logic [CW-1:0] lane_idx;
  logic [2:0]    lane_reg;
  logic [L-1:0]  lane_data;
  logic          full_hit;

  vector_lane_loader #(
    .I  (I),
    .L  (L),
    .CW (CW)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_addr   (ld_addr),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .lane_we   (lane_we),
    .lane_idx  (lane_idx),
    .lane_reg  (lane_reg),
    .lane_data (lane_data)
  );

  assign full_hit = wr_en && (wr_addr[3] == VBANK_HI_BASE[3]);

  // A masked full write to the same lane wins over the loader's element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) begin
        bank[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < I; k++) begin
          if (full_hit && (wr_addr[2:0] == 3'(r)) && wr_mask[k]) begin
            bank[r][k] <= wr_data[k];
          end else if (lane_we && (lane_reg == 3'(r)) && (lane_idx == CW'(k))) begin
            bank[r][k] <= lane_data;
          end
        end
      end
    end
  end

  assign D08 = bank[0];
  assign D09 = bank[1];
  assign D10 = bank[2];
  assign D11 = bank[3];
  assign D12 = bank[4];
  assign D13 = bank[5];
  assign D14 = bank[6];
  assign D15 = bank[7];

endmodule

// File: tb/tb_vector_reg_bank_hi.sv
// Self-checking bench for vector_reg_bank_hi: directed steps followed by a
// randomized phase, all checked against a lane-array reference model.
module tb_vector_reg_bank_hi;

  localparam int I = 20;
  localparam int L = 8;

  logic                clk;
  logic                rst_n;
  logic                wr_en;
  logic [3:0]          wr_addr;
  logic [I-1:0]        wr_mask;
  logic [I-1:0][L-1:0] wr_data;
  logic                ld_start;
  logic [3:0]          ld_addr;
  logic                ld_valid;
  logic [L-1:0]        ld_data;
  logic                ld_ready;
  logic                ld_busy;
  logic                ld_done;
  logic                ld_err;
  logic [I-1:0][L-1:0] d08, d09, d10, d11, d12, d13, d14, d15;

  vector_reg_bank_hi #(.I(I), .L(L)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mask  (wr_mask),
    .wr_data  (wr_data),
    .ld_start (ld_start),
    .ld_addr  (ld_addr),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .D08      (d08),
    .D09      (d09),
    .D10      (d10),
    .D11      (d11),
    .D12      (d12),
    .D13      (d13),
    .D14      (d14),
    .D15      (d15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain lane arrays plus a phase number for the loader.
  logic [L-1:0] mem [8][I];
  int mphase;
  int mcnt;
  int mreg;
  bit merr;

  int tests;
  int failures;
  int done_count;

  function automatic logic [I*L-1:0] getD(input int r);
    case (r)
      0: return d08;
      1: return d09;
      2: return d10;
      3: return d11;
      4: return d12;
      5: return d13;
      6: return d14;
      default: return d15;
    endcase
  endfunction

  function automatic logic [I*L-1:0] modelVec(input int r);
    logic [I*L-1:0] v;
    for (int k = 0; k < I; k++) v[k*L +: L] = mem[r][k];
    return v;
  endfunction

  task automatic compare(input string tag, input logic [I*L-1:0] obs, input logic [I*L-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < I; k++) mem[r][k] = '0;
    mphase = 0;
    mcnt   = 0;
    mreg   = 0;
    merr   = 1'b0;
  endtask

  // Element first, then the masked full write, so the full write wins a shared lane.
  task automatic modelStep();
    int next_phase;
    next_phase = mphase;
    merr = 1'b0;
    if (mphase == 0) begin
      if (ld_start) begin
        if (ld_addr >= 8) begin
          next_phase = 1;
          mreg = int'(ld_addr) - 8;
          mcnt = 0;
        end else begin
          merr = 1'b1;
        end
      end
    end else if (mphase == 1) begin
      if (ld_valid) begin
        mem[mreg][mcnt] = ld_data;
        mcnt++;
        if (mcnt == I) next_phase = 2;
      end
    end else begin
      next_phase = 0;
    end
    if (wr_en && wr_addr >= 8)
      for (int k = 0; k < I; k++)
        if (wr_mask[k]) mem[int'(wr_addr) - 8][k] = wr_data[k];
    mphase = next_phase;
  endtask

  task automatic checkOutput(input string tag);
    for (int r = 0; r < 8; r++)
      compare($sformatf("%s D%0d", tag, r + 8), getD(r), modelVec(r));
    compare({tag, " ld_busy"},  ld_busy,  (mphase != 0));
    compare({tag, " ld_ready"}, ld_ready, (mphase == 1));
    compare({tag, " ld_done"},  ld_done,  (mphase == 2));
    compare({tag, " ld_err"},   ld_err,   merr);
  endtask

  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    if (ld_done) done_count++;
    checkOutput(tag);
    ld_start = 1'b0;
    wr_en    = 1'b0;
  endtask

  task automatic resetPulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, " async"});
    @(posedge clk);
    #1;
    checkOutput({tag, " held"});
    #3 rst_n = 1'b1;
    wr_en    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic randomData();
    for (int k = 0; k < I; k++) wr_data[k] = L'($urandom);
  endtask

  initial begin
    logic [I*L-1:0] exp_vec;
    int accepted;
    int guard;
    tests      = 0;
    failures   = 0;
    done_count = 0;
    rst_n      = 1'b0;
    wr_en      = 1'b1;
    wr_addr    = 4'b1001;
    wr_mask    = '1;
    wr_data    = '1;
    ld_start   = 1'b0;
    ld_addr    = 4'b0000;
    ld_valid   = 1'b0;
    ld_data    = '0;
    modelReset();
    @(posedge clk);
    #1;
    resetPulse("reset0");

    // Fill a register, then pull reset asynchronously in the middle of a cycle.
    wr_en = 1'b1; wr_addr = 4'b1001; wr_mask = '1; randomData();
    applyStimulus("prefill");
    wr_en = 1'b1; wr_addr = 4'b1110; wr_mask = '1; randomData();
    resetPulse("reset1");
    compare("reset1 D09 zero", d09, '0);

    wr_en = 1'b1; wr_addr = 4'b1010; wr_mask = '1;
    for (int k = 0; k < I; k++) wr_data[k] = L'(k);
    applyStimulus("full write D10");
    for (int k = 0; k < I; k++) exp_vec[k*L +: L] = L'(k);
    compare("D10 lane k=k", d10, exp_vec);

    wr_en = 1'b1; wr_addr = 4'b1010; wr_mask = I'(1); wr_data = '1;
    applyStimulus("mask bit0");
    exp_vec[L-1:0] = 8'hFF;
    compare("D10 only lane0", d10, exp_vec);

    wr_en = 1'b1; wr_addr = 4'b0011; wr_mask = '1; randomData();
    applyStimulus("low addr write");
    compare("D10 untouched", d10, exp_vec);

    // Serial load of V15 with ld_valid toggling every cycle.
    ld_start = 1'b1; ld_addr = 4'b1111;
    applyStimulus("ld15 start");
    done_count = 0;
    accepted = 0;
    guard = 0;
    while (accepted < I && guard < 4 * I) begin
      ld_valid = (guard % 2 == 0);
      ld_data  = 8'h10 + L'(accepted);
      if (ld_valid && mphase == 1) accepted++;
      applyStimulus("ld15 elem");
      guard++;
    end
    compare("ld15 accepts", accepted, I);
    compare("ld15 done after last", ld_done, 1'b1);
    ld_valid = 1'b0;
    for (int c = 0; c < 3; c++) applyStimulus("ld15 tail");
    compare("ld15 done pulses", done_count, 1);
    for (int k = 0; k < I; k++) exp_vec[k*L +: L] = 8'h10 + L'(k);
    compare("D15 loaded", d15, exp_vec);

    ld_start = 1'b1; ld_addr = 4'b0101;
    applyStimulus("reject");
    compare("reject ld_err", ld_err, 1'b1);
    compare("reject idle", ld_busy, 1'b0);
    applyStimulus("reject after");

    // Start V13, try to retarget to V8 mid-load; the original target must stick.
    ld_start = 1'b1; ld_addr = 4'b1101;
    applyStimulus("ld13 start");
    ld_valid = 1'b1; ld_data = 8'hA0;
    applyStimulus("ld13 elem0");
    ld_start = 1'b1; ld_addr = 4'b1000; ld_data = 8'hA1;
    applyStimulus("ld13 restart ignored");
    compare("ld13 no err", ld_err, 1'b0);
    for (int k = 2; k < I; k++) begin
      ld_data = 8'hA0 + L'(k);
      applyStimulus("ld13 elem");
    end
    ld_valid = 1'b0;
    applyStimulus("ld13 done");
    for (int k = 0; k < I; k++) exp_vec[k*L +: L] = 8'hA0 + L'(k);
    compare("D13 loaded", d13, exp_vec);
    compare("D08 untouched", d08, '0);

    // Collision on V12 at lane 3, then reset in the middle of the load.
    ld_start = 1'b1; ld_addr = 4'b1100;
    applyStimulus("ld12 start");
    ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ld_data = 8'h30 + L'(k);
      applyStimulus("ld12 elem");
    end
    ld_data = 8'h55;
    wr_en = 1'b1; wr_addr = 4'b1100; wr_mask = I'(1) << 3; wr_data = '0; wr_data[3] = 8'hAA;
    applyStimulus("ld12 collide");
    ld_data = 8'h66;
    applyStimulus("ld12 elem4");
    ld_valid = 1'b0;
    compare("D12 lane3 full wins", d12[3], 8'hAA);
    compare("D12 lane4 advanced", d12[4], 8'h66);
    done_count = 0;
    resetPulse("reset mid-load");
    compare("D12 cleared", d12, '0);
    for (int c = 0; c < 3; c++) applyStimulus("post reset");
    compare("no done after reset", done_count, 0);

    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 4'($urandom);
      wr_mask  = I'($urandom);
      randomData();
      ld_start = ($urandom_range(0, 7) == 0);
      ld_addr  = 4'($urandom);
      ld_valid = 1'($urandom);
      ld_data  = L'($urandom);
      applyStimulus("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
